// File: rtl/mem_port_sched_if.sv
// Bundle of the fetch, data and memory-side signals around the unified memory port scheduler.
// master is the scheduler's view; slave is the view of the pipeline and memory around it.
interface mem_port_sched_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_front;
  logic        mem_wb_bubble;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
           stall_front, mem_wb_bubble
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
           stall_front, mem_wb_bubble
  );
endinterface

// File: rtl/mem_port_sched.sv
// Arbitrates fetch and MEM-stage data accesses onto one variable-latency memory port,
// with a starvation bound on fetch and the front-end stall / MEM_WB bubble controls.
module mem_port_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_sched_if.master sched_if
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             if_done_q, if_done_d;
  logic             d_done_q, d_done_d;
  logic             arb_en;
  logic             grant_d;
  logic             grant_i;
  logic             ready_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    // The done cycle still sees the finished request held high, so no arbitration then.
    arb_en      = !(if_done_q || d_done_q);
    ready_ok    = sched_if.mem_ready && mem_req_q;

    case (state_q)
      IDLE: begin
        if (arb_en) begin
          if (sched_if.d_req && (!sched_if.if_req || starve_q < LIMIT)) begin
            grant_d = 1'b1;
          end else if (sched_if.if_req) begin
            grant_i = 1'b1;
          end
        end
      end
      D_BUSY: begin
        if (ready_ok) begin
          if (!mem_we_q) d_rdata_d = sched_if.mem_rdata;
          d_done_d  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      I_BUSY: begin
        if (ready_ok) begin
          if_rdata_d = sched_if.mem_rdata;
          if_done_d  = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_d) begin
      state_d     = D_BUSY;
      mem_req_d   = 1'b1;
      mem_we_d    = sched_if.d_we;
      mem_addr_d  = sched_if.d_addr;
      mem_wdata_d = sched_if.d_wdata;
    end else if (grant_i) begin
      state_d    = I_BUSY;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = sched_if.if_addr;
    end

    if (!sched_if.if_req || grant_i) begin
      starve_d = '0;
    end else if (grant_d && starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign sched_if.mem_req       = mem_req_q;
  assign sched_if.mem_we        = mem_we_q;
  assign sched_if.mem_addr      = mem_addr_q;
  assign sched_if.mem_wdata     = mem_wdata_q;
  assign sched_if.if_rdata      = if_rdata_q;
  assign sched_if.d_rdata       = d_rdata_q;
  assign sched_if.if_done       = if_done_q;
  assign sched_if.d_done        = d_done_q;
  assign sched_if.stall_front   = (sched_if.d_req & ~d_done_q) | (sched_if.if_req & ~if_done_q);
  assign sched_if.mem_wb_bubble = sched_if.d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: table of single transactions, starvation and reset sequences,
// with a memory responder and per-requester expectation queues checked on each done pulse.
module tb_mem_port_sched;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waitc;
    int          lat;
  } vec_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waitc;
  } exp_t;

  logic clk;
  logic rst;
  mem_port_sched_if bus();

  mem_port_sched #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sched_if (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t dq[$];
  exp_t iq[$];
  bit   glog[$];
  logic [31:0] mem_img [logic [31:0]];
  bit   resp_en = 1'b1;
  int   resp_wait = 0;
  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return ~a;
  endfunction

  // Memory responder: ready arrives in the (resp_wait+1)-th cycle of mem_req.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        if (rst || !bus.mem_req) begin
          bus.mem_ready = 1'b0;
          cnt = 0;
        end else begin
          if (cnt == resp_wait) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rd_word(bus.mem_addr);
            if (bus.mem_we) mem_img[bus.mem_addr] = bus.mem_wdata;
          end else begin
            bus.mem_ready = 1'b0;
          end
          cnt++;
        end
      end
    end
  end

  // Monitor: captures each memory access and scores it against the queue on its done pulse.
  initial begin
    bit          cap_vld, cap_we, prev_done, done_now;
    logic [31:0] cap_addr, cap_wdata;
    int          cap_cyc;
    exp_t        e;
    cap_vld = 0; prev_done = 0; cap_cyc = 0; cap_we = 0; cap_addr = '0; cap_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cap_vld = 0;
        prev_done = 0;
      end else begin
        if (bus.mem_req) begin
          if (!cap_vld) begin
            cap_vld = 1; cap_we = bus.mem_we; cap_addr = bus.mem_addr;
            cap_wdata = bus.mem_wdata; cap_cyc = 1;
          end else begin
            check("mem_addr stable", bus.mem_addr, cap_addr);
            check("mem_we stable", 32'(bus.mem_we), 32'(cap_we));
            cap_cyc++;
          end
        end
        done_now = bus.d_done | bus.if_done;
        if (done_now) begin
          check("single done at a time", 32'(bus.d_done & bus.if_done), 0);
          check("done one cycle", 32'(prev_done), 0);
          check("access seen before done", 32'(cap_vld), 1);
          if (bus.d_done) begin
            if (dq.size() == 0) check("unexpected d_done", 1, 0);
            else begin
              e = dq.pop_front();
              glog.push_back(1'b1);
              check("d mem_addr", cap_addr, e.addr);
              check("d mem_we", 32'(cap_we), 32'(e.we));
              if (e.we) check("d mem_wdata", cap_wdata, e.wdata);
              check("d_rdata", bus.d_rdata, e.rdata);
              check("d mem_req cycles", cap_cyc, e.waitc + 1);
            end
          end else begin
            if (iq.size() == 0) check("unexpected if_done", 1, 0);
            else begin
              e = iq.pop_front();
              glog.push_back(1'b0);
              check("if mem_addr", cap_addr, e.addr);
              check("if mem_we", 32'(cap_we), 0);
              check("if_rdata", bus.if_rdata, e.rdata);
              check("if mem_req cycles", cap_cyc, e.waitc + 1);
            end
          end
          cap_vld = 0;
        end
        prev_done = done_now;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   cyc;
    bit   seen, stall_ok;
    resp_wait = v.waitc;
    e = '{we: v.we, addr: v.addr, wdata: v.wdata, rdata: v.rdata, waitc: v.waitc};
    @(posedge clk); #1;
    if (v.is_d) begin
      bus.d_req = 1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      dq.push_back(e);
    end else begin
      bus.if_req = 1; bus.if_addr = v.addr;
      iq.push_back(e);
    end
    cyc = 0; seen = 0; stall_ok = 1;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (v.is_d ? bus.d_done : bus.if_done) seen = 1;
      else if (bus.stall_front !== 1'b1 || bus.mem_wb_bubble !== v.is_d) stall_ok = 0;
    end
    check("done within budget", 32'(seen), 1);
    check("request-to-done latency", cyc - 1, v.lat);
    check("stall/bubble while pending", 32'(stall_ok), 1);
    check("stall_front in done cycle", 32'(bus.stall_front), 0);
    check("mem_wb_bubble in done cycle", 32'(bus.mem_wb_bubble), 0);
    @(posedge clk); #1;
    bus.d_req = 0; bus.if_req = 0;
    @(negedge clk);
    check("no re-grant after done", 32'(bus.mem_req), 0);
  endtask

  initial begin
    int cyc, dones, nd;
    logic [31:0] pat;
    exp_t e;

    vecs[0] = '{1, 0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1, 3};
    vecs[1] = '{1, 1, 32'h0000_0200, 32'h1234_5678, 32'hDEAD_BEEF, 0, 2};
    vecs[2] = '{0, 0, 32'h0000_0040, 32'h0,         32'h0050_0093, 2, 4};
    vecs[3] = '{1, 0, 32'h0000_0200, 32'h0,         32'h1234_5678, 0, 2};
    vecs[4] = '{0, 0, 32'h0000_0044, 32'h0,         32'hFFFF_FFBB, 0, 2};
    vecs[5] = '{1, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0003, 3, 5};
    mem_img[32'h0000_0100] = 32'hDEAD_BEEF;
    mem_img[32'h0000_0040] = 32'h0050_0093;

    rst = 1;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset mem_req", 32'(bus.mem_req), 0);
    check("reset mem_we", 32'(bus.mem_we), 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset done pulses", 32'(bus.d_done | bus.if_done), 0);
    check("reset d_rdata", bus.d_rdata, 0);
    check("reset if_rdata", bus.if_rdata, 0);
    check("reset stall_front", 32'(bus.stall_front), 0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Fetch and data both pending: four data grants, then fetch, then the last data access.
    resp_wait = 0;
    glog.delete();
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 32'h80;
    iq.push_back('{we: 0, addr: 32'h80, wdata: 0, rdata: ~32'h80, waitc: 0});
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    dq.push_back('{we: 0, addr: 32'h300, wdata: 0, rdata: ~32'h300, waitc: 0});
    nd = 1; cyc = 0; dones = 0;
    while (dones < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.d_done) begin
        dones++;
        if (nd < 5) begin
          bus.d_addr = 32'h300 + 32'(nd * 4);
          e = '{we: 0, addr: bus.d_addr, wdata: 0, rdata: ~bus.d_addr, waitc: 0};
          dq.push_back(e);
          nd++;
        end else begin
          bus.d_req = 0;
        end
      end
      if (bus.if_done) begin
        dones++;
        bus.if_req = 0;
      end
    end
    check("starvation sequence finished", dones, 6);
    pat = '0;
    foreach (glog[k]) pat = {pat[30:0], glog[k]};
    check("grant count", glog.size(), 6);
    check("grant order D D D D I D", pat, 32'b111101);

    // mem_ready with nothing outstanding must be ignored.
    resp_en = 0;
    @(posedge clk); #1;
    bus.d_req = 0; bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle ready: mem_req", 32'(bus.mem_req), 0);
      check("idle ready: done", 32'(bus.d_done | bus.if_done), 0);
    end
    @(posedge clk); #1;
    bus.mem_ready = 0;

    // Reset during D_BUSY, then a late mem_ready.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_req && cyc < 10);
    check("load reaches memory before reset", 32'(bus.mem_req), 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; bus.d_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("post-reset mem_req", 32'(bus.mem_req), 0);
    check("post-reset d_done", 32'(bus.d_done), 0);
    check("post-reset mem_addr", bus.mem_addr, 0);
    check("post-reset d_rdata", bus.d_rdata, 0);
    check("post-reset if_rdata", bus.if_rdata, 0);
    check("post-reset stall_front", 32'(bus.stall_front), 0);
    check("post-reset mem_wb_bubble", 32'(bus.mem_wb_bubble), 0);
    @(posedge clk); #1;
    bus.mem_ready = 0;
    @(negedge clk);
    check("late ready: d_done", 32'(bus.d_done), 0);
    check("late ready: mem_req", 32'(bus.mem_req), 0);
    check("late ready: d_rdata", bus.d_rdata, 0);

    check("expectation queues drained", dq.size() + iq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Scheduler for the single-port unified memory shared by instruction fetch (IF) and the data access of the MEM stage (loads/stores leaving EX_MEM).
- Arbitrates the two requesters and sequences variable-latency transactions through a ready handshake.
- Generates the pipeline stall and the MEM_WB bubble control, so the MEM_WB register captures load data only on completed accesses.
- Starvation counter bounds how long fetch can be locked out by back-to-back data accesses.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while if_req is pending before IF is forced to win (legal range 1..15).
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- if_req  input  1  fetch request; held until if_done.
- if_addr  input  32  fetch address.
- if_rdata  output  32  fetched word; registered, valid while if_done=1.
- if_done  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request (Mem_Read|Mem_Write of the EX_MEM instruction); held until d_done.
- d_we  input  1  1=store, 0=load.
- d_addr  input  32  data address (result_EX_MEM).
- d_wdata  input  32  store data.
- d_rdata  output  32  load data to Read_Data of MEM_WB; registered, valid while d_done=1.
- d_done  output  1  one-cycle data completion pulse.
- mem_req  output  1  memory request; registered.
- mem_we  output  1  memory write enable; registered.
- mem_addr  output  32  memory address; registered.
- mem_wdata  output  32  memory write data; registered.
- mem_rdata  input  32  memory read data, valid with mem_ready.
- mem_ready  input  1  memory completion; sampled only while mem_req=1.
- stall_front  output  1  freeze PC, IF_ID, ID_EX, EX_MEM; combinational.
- mem_wb_bubble  output  1  MEM_WB loads a bubble (Reg_Write=0, Mem_to_Reg=0); combinational.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE; starve_cnt=0; mem_req, mem_we, if_done, d_done=0; mem_addr, mem_wdata, if_rdata, d_rdata=0.
- Reset mid-transaction: the transaction is abandoned and mem_req drops on the next edge. A late mem_ready seen while mem_req=0 is ignored.
- FSM has three states: IDLE, D_BUSY, I_BUSY.
- IDLE arbitration:
  - Data is granted if d_req and (!if_req or starve_cnt<STARVE_LIMIT).
  - Otherwise fetch is granted if if_req.
- On grant:
  - Next edge latches addr/we/wdata into mem_*, sets mem_req=1 and moves to D_BUSY or I_BUSY.
  - A fetch grant sets mem_we=0.
- BUSY state:
  - mem_* stay stable until mem_ready=1.
  - On mem_ready=1, the next edge:
    - captures mem_rdata into d_rdata or if_rdata (store: d_rdata unchanged);
    - pulses the matching done for exactly one cycle;
    - clears mem_req;
    - returns to IDLE.
- Minimum latency: grant in IDLE at cycle 0, mem_req=1 in cycle 1, mem_ready in cycle 1, done=1 in cycle 2. Next grant is no earlier than cycle 3, since the done cycle is spent in IDLE with the request still asserted.
- Done-cycle rule:
  - In the cycle done=1, IDLE must not re-grant the same requester.
  - Arbitration is suppressed in any cycle where if_done|d_done=1.
  - The requester presents its next request from the following cycle.
- Starvation counter:
  - starve_cnt increments (saturating) on each data grant made while if_req=1.
  - It clears on any fetch grant or in any cycle with if_req=0.
  - A data grant taken at starve_cnt==STARVE_LIMIT is illegal.
- stall_front = (d_req & ~d_done) | (if_req & ~if_done).
- mem_wb_bubble = d_req & ~d_done. A completing load advances into MEM_WB on the d_done edge with d_rdata.
- Non-memory instructions (d_req=0) never stall the back end.
- mem_ready arriving in IDLE or on the same edge as reset is ignored.
- No address alignment or range checking is performed.

Test Plan:
- Reset, then single load: d_req=1, d_we=0, d_addr=0x100, mem_ready after 2 cycles with mem_rdata=0xDEADBEEF -> mem_req high 2 cycles with mem_addr=0x100; d_done pulses 1 cycle; d_rdata=0xDEADBEEF; stall_front and mem_wb_bubble high until the d_done cycle.
- Store: d_we=1, d_wdata=0x12345678, zero-wait ready -> mem_we=1 and mem_wdata=0x12345678 in cycle 1; d_done in cycle 2; d_rdata unchanged.
- Simultaneous if_req and d_req, STARVE_LIMIT=4, d_req re-asserted after each done -> 4 data grants, then fetch granted; starve_cnt returns to 0.
- Fetch only, if_addr=0x40, ready after 3 cycles, mem_rdata=0x00500093 -> if_done 1 cycle, if_rdata=0x00500093, stall_front low in the if_done cycle.
- rst asserted mid D_BUSY, mem_ready pulsed the cycle after -> mem_req=0, no d_done, state IDLE, all outputs at reset values.
- mem_ready pulsed while IDLE with no requests -> no done pulses, mem_req stays 0.
